// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default transmitter buffer depth and the
// TX scheduler state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned TXBUF_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } tx_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts just after ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         gnt
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    if (enable) begin
      for (int unsigned off = NUM_REQ; off >= 1; off--) begin
        idx = PtrW'((32'(ptr) + off) % NUM_REQ);
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin loading
// of the transmitter buffer, then one framed send per buffered byte.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TXBUF_DEPTH    = TXBUF_DEPTH_DEFAULT,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [UART_DATA_BITS*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              tx_load,
  output logic [UART_DATA_BITS-1:0]         tx_data,
  output logic                              tx_send,
  input  logic                              tx_done,
  output logic [2:0]                        pending_count,
  output logic                              busy,
  output logic                              err_timeout,
  input  logic                              err_clr
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [2:0]      Depth   = 3'(TXBUF_DEPTH);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

  tx_sched_state_t           state_q, state_d;
  logic [PtrW-1:0]           ptr_q, ptr_d;
  logic [2:0]                pending_q, pending_d;
  logic [GapW-1:0]           gap_q, gap_d;
  logic [ToW-1:0]            to_q, to_d;
  logic                      load_q, load_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      err_q, err_d;

  logic                      arb_en;
  logic [NUM_REQ-1:0]        gnt;
  logic [PtrW-1:0]           gnt_idx;
  logic [UART_DATA_BITS-1:0] gnt_byte;

  // Grants only while idle with buffer room; gated by rst_n so nothing is
  // accepted while reset is held.
  assign arb_en = rst_n && (state_q == IDLE) && (pending_q < Depth);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PtrW'(i);
        gnt_byte = req_data[UART_DATA_BITS*i +: UART_DATA_BITS];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    gap_d     = '0;
    to_d      = '0;
    load_d    = 1'b0;
    data_d    = data_q;
    err_d     = err_clr ? 1'b0 : err_q;

    unique case (state_q)
      IDLE: begin
        if (|gnt) begin
          state_d   = LOAD;
          load_d    = 1'b1;
          data_d    = gnt_byte;
          ptr_d     = gnt_idx;
          pending_d = pending_q + 3'd1;
        end else if (pending_q != 3'd0) begin
          state_d = SEND;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      SEND: begin
        if (tx_done) begin
          state_d   = GAP;
          pending_d = pending_q - 3'd1;
        end else if (to_q == ToLast) begin
          // Abandon the frame; the byte counts as consumed. Set beats err_clr.
          state_d   = GAP;
          pending_d = pending_q - 3'd1;
          err_d     = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GapLast) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      pending_q <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      load_q    <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      load_q    <= load_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  assign req_ready     = gnt;
  assign tx_load       = load_q;
  assign tx_data       = data_q;
  assign tx_send       = (state_q == SEND);
  assign pending_count = pending_q;
  assign busy          = (state_q != IDLE) || (pending_q != 3'd0);
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a cycle-level reference model
// checked on every falling edge.
module tb_uart_tx_scheduler;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TO    = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_done;
  logic [2:0]  pending_count;
  logic        busy;
  logic        err_timeout;
  logic        err_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ        (NREQ),
    .TXBUF_DEPTH    (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .tx_load       (tx_load),
    .tx_data       (tx_data),
    .tx_send       (tx_send),
    .tx_done       (tx_done),
    .pending_count (pending_count),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .err_clr       (err_clr)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] v, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      if (v[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  // Reference model: a frame is an age counter (-1 = no frame), a gap is a
  // count of remaining idle cycles, a load is a one-cycle flag.
  bit       m_live    = 1'b0;
  int       m_pending = 0;
  int       m_last    = 0;
  int       m_age     = -1;
  int       m_gap     = 0;
  bit       m_load    = 1'b0;
  bit [7:0] m_data    = '0;
  bit       m_err     = 1'b0;

  initial begin
    forever begin
      logic [1:0] e_rdy;
      int         g;
      bit         idle;
      bit         n_err;
      @(negedge clk);
      idle  = !m_load && (m_age < 0) && (m_gap == 0);
      g     = rr_pick(req_valid, m_last);
      e_rdy = '0;
      if (rst_n && idle && m_pending < DEPTH && g >= 0) e_rdy[g] = 1'b1;
      if (m_live) begin
        chk("cyc_req_ready", req_ready, e_rdy);
        chk("cyc_tx_load", tx_load, m_load);
        chk("cyc_tx_data", tx_data, m_data);
        chk("cyc_tx_send", tx_send, (m_age >= 0));
        chk("cyc_pending", pending_count, m_pending);
        chk("cyc_busy", busy, (!idle || m_pending != 0));
        chk("cyc_err", err_timeout, m_err);
      end
      if (!rst_n) begin
        m_live = 1'b1; m_pending = 0; m_last = 0; m_age = -1; m_gap = 0;
        m_load = 1'b0; m_data = '0; m_err = 1'b0;
      end else if (m_live) begin
        n_err = (m_age == TO - 1 && !tx_done) ? 1'b1 : (err_clr ? 1'b0 : m_err);
        if (m_load) begin
          m_load = 1'b0;
        end else if (m_age >= 0) begin
          if (tx_done || m_age == TO - 1) begin
            m_age = -1;
            m_pending--;
            m_gap = GAP;
          end else begin
            m_age++;
          end
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (e_rdy != 0) begin
          m_load = 1'b1;
          m_data = req_data[8*g +: 8];
          m_last = g;
          m_pending++;
        end else if (m_pending > 0) begin
          m_age = 0;
        end
        m_err = n_err;
      end
    end
  end

  logic [7:0] d0, d1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick while producers stream: bump a producer's byte after it is accepted.
  task automatic tick_rr();
    logic [1:0] rdy;
    rdy = req_ready;
    tick();
    if (rdy[0]) d0 = d0 + 8'd1;
    if (rdy[1]) d1 = d1 + 8'd1;
    req_data = {d1, d0};
    #1;
  endtask

  task automatic wait_send();
    for (int n = 0; n < 30 && !tx_send; n++) tick();
    chk("send_start", tx_send, 1);
  endtask

  task automatic frame(input int delay);
    wait_send();
    repeat (delay - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    int         n;
    logic [7:0] exp_b [4];
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_pending", pending_count, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_tx_load", tx_load, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    tick();

    // Single request.
    req_valid = 2'b01; req_data = 16'h0041; #1;
    chk("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    chk("t1_load", tx_load, 1);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_pending", pending_count, 1);
    tick();
    chk("t1_load_fall", tx_load, 0);
    chk("t1_data_hold", tx_data, 8'h41);
    frame(40);
    chk("t1_send_drop", tx_send, 0);
    chk("t1_pending0", pending_count, 0);
    chk("t1_busy_gap", busy, 1);
    repeat (GAP - 1) tick();
    chk("t1_busy_gap_end", busy, 1);
    tick();
    chk("t1_busy_idle", busy, 0);

    // Leave requester 1 as last granted so streaming starts at requester 0.
    req_valid = 2'b10; req_data = 16'h5A00;
    tick();
    req_valid = '0;
    frame(20);
    repeat (GAP) tick();

    // Round-robin streaming from both requesters.
    exp_b[0] = 8'hA0; exp_b[1] = 8'hB0; exp_b[2] = 8'hA1; exp_b[3] = 8'hB1;
    d0 = 8'hA0; d1 = 8'hB0;
    req_valid = 2'b11; req_data = {d1, d0}; #1;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      tick_rr();
      if (tx_load) begin
        chk($sformatf("t2_load%0d", k), tx_data, exp_b[k]);
        k++;
      end
    end
    chk("t2_loads", k, 4);
    chk("t2_pending", pending_count, 4);

    // Full buffer: no grants, frame, then one more byte after the gap.
    tick_rr();
    chk("t3_full_ready", req_ready, 0);
    frame(30);
    chk("t3_pending3", pending_count, 3);
    chk("t3_gap_ready", req_ready, 0);
    repeat (GAP - 1) tick();
    chk("t3_gap_last_ready", req_ready, 0);
    tick(); #1;
    chk("t3_ready", req_ready, 2'b01);
    tick_rr();
    req_valid = '0;
    chk("t3_load", tx_load, 1);
    chk("t3_data", tx_data, 8'hA2);
    chk("t3_pending4", pending_count, 4);

    // Reset mid-frame with three bytes pending.
    frame(10);
    repeat (GAP) tick();
    wait_send();
    chk("t5_pending3", pending_count, 3);
    repeat (3) tick();
    req_valid = 2'b11; rst_n = 1'b0;
    tick();
    chk("t5_send", tx_send, 0);
    chk("t5_pending", pending_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 0);
    tick();
    chk("t5_ready_hold", req_ready, 0);
    rst_n = 1'b1; req_valid = '0;
    tick();

    // Timeout, sticky error, clear, then clear coincident with a new timeout.
    req_valid = 2'b01; req_data = 16'h0077;
    tick();
    req_valid = '0;
    wait_send();
    n = 0;
    while (tx_send && n < 100) begin n++; tick(); end
    chk("t4_send_len", n, TO);
    chk("t4_err", err_timeout, 1);
    chk("t4_pending", pending_count, 0);
    repeat (5) tick();
    chk("t4_err_hold", err_timeout, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", err_timeout, 0);
    repeat (GAP) tick();
    req_valid = 2'b01; req_data = 16'h0078;
    tick();
    req_valid = '0;
    wait_send();
    n = 0;
    while (tx_send && n < 100) begin
      n++;
      if (n == TO) err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
    end
    chk("t4_send_len2", n, TO);
    chk("t4_set_wins", err_timeout, 1);

    // Spurious tx_done in IDLE and in GAP.
    repeat (GAP) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t6_idle_pending", pending_count, 0);
    chk("t6_idle_busy", busy, 0);
    req_valid = 2'b10; req_data = 16'h3300;
    tick();
    req_valid = '0;
    frame(15);
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t6_gap_pending", pending_count, 0);
    chk("t6_gap_busy", busy, 1);
    chk("t6_gap_send", tx_send, 0);
    repeat (GAP) tick();
    chk("t6_end_busy", busy, 0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
